// File: rtl/tstate_pkg.sv
// Shared constants for the T-state ring: default size, ring ceiling, idle code,
// and a multi-hot test used by the optional illegal-state recovery.
package tstate_pkg;
   localparam int DEF_N_STATES = 6;
   localparam int MAX_STATES   = 16;
   localparam int IDLE_STATE   = 0;

   // True when more than one bit is set; zero and one-hot both return 0.
   function automatic logic multi_hot(input logic [MAX_STATES-1:0] v);
      return (v & (v - MAX_STATES'(1))) != '0;
   endfunction
endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder; bit i maps to value i+1, zero maps to zero.
module onehot_enc #(
   parameter int W     = 6,
   parameter int OUT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     onehot,
   output logic [OUT_W-1:0] bin
);
   genvar gb, gi;
   generate
      for (gb = 0; gb < OUT_W; gb++) begin : g_bit
         logic [W-1:0] sel;
         // Output bit gb is the OR of every input whose code (gi+1) has bit gb set.
         for (gi = 0; gi < W; gi++) begin : g_in
            assign sel[gi] = onehot[gi] & ((((gi + 1) >> gb) % 2) == 1);
         end
         assign bin[gb] = |sel;
      end
   endgenerate
endmodule

// File: rtl/tstate_ring.sv
// One-hot T-state ring with runtime length, hold and early end, clocked on negedge CLK.
// Optional illegal-state recovery is enabled by defining TSTATE_RING_SELFCHECK_EN.
module tstate_ring
   import tstate_pkg::*;
#(
   parameter  int N_STATES = DEF_N_STATES,
   localparam int IDX_W    = $clog2(N_STATES + 1)
) (
   input  logic                CLK,
   input  logic                nCLR,
   input  logic                HLT,
   input  logic                nEND,
   input  logic [IDX_W-1:0]    LEN,
   output logic [N_STATES-1:0] state,
   output logic [IDX_W-1:0]    tidx,
   output logic                last,
   output logic                ERR
);
   localparam logic [N_STATES-1:0] T1      = N_STATES'(1);
   localparam logic [N_STATES-1:0] IDLE    = N_STATES'(IDLE_STATE);
   localparam logic [IDX_W-1:0]    N_LEN   = IDX_W'(N_STATES);
   localparam logic [IDX_W-1:0]    MIN_LEN = IDX_W'(2);

   logic [N_STATES-1:0] state_reg, state_next;
   logic [IDX_W-1:0]    eff_len;
   logic [N_STATES-1:0] last_mask, low_mask;
   logic                at_or_past_end;
   logic                illegal;

   assign eff_len   = (LEN >= MIN_LEN && LEN <= N_LEN) ? LEN : N_LEN;
   assign last_mask = T1 << (eff_len - IDX_W'(1));
   assign low_mask  = last_mask - T1;
   // Any set bit at or beyond the final position wraps, including after LEN shrinks.
   assign at_or_past_end = |(state_reg & ~low_mask);
   assign illegal        = multi_hot(MAX_STATES'(state_reg));

   always_comb begin
      state_next = state_reg;
`ifdef TSTATE_RING_SELFCHECK_EN
      if (illegal)
         state_next = T1;
      else
`endif
      if (HLT)
         state_next = state_reg;
      else if (illegal)
         state_next = state_reg;
      else if (state_reg == IDLE)
         state_next = T1;
      else if (!nEND)
         state_next = T1;
      else if (at_or_past_end)
         state_next = T1;
      else
         state_next = state_reg << 1;
   end

   always_ff @(negedge CLK or negedge nCLR) begin
      if (!nCLR)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

`ifdef TSTATE_RING_SELFCHECK_EN
   logic err_reg;
   // ERR marks only the cycle right after a recovery, independent of HLT.
   always_ff @(negedge CLK or negedge nCLR) begin
      if (!nCLR)
         err_reg <= 1'b0;
      else
         err_reg <= illegal;
   end
   assign ERR = err_reg;
`else
   assign ERR = 1'b0;
`endif

   onehot_enc #(
      .W     (N_STATES),
      .OUT_W (IDX_W)
   ) u_enc (
      .onehot (state_reg),
      .bin    (tidx)
   );

   assign state = state_reg;
   assign last  = |(state_reg & last_mask);
endmodule

// File: tb/tb_tstate_ring.sv
// Directed plus randomized bench for tstate_ring (N_STATES=6) against a position-counter model.
module tb_tstate_ring;
   localparam int N = 6;
   localparam int W = 3;

   logic         CLK = 1'b1;
   logic         nCLR = 1'b0;
   logic         HLT = 1'b0;
   logic         nEND = 1'b1;
   logic [W-1:0] LEN = '0;
   logic [N-1:0] state;
   logic [W-1:0] tidx;
   logic         last;
   logic         ERR;

   int errors = 0;
   int checks = 0;
   int pos = 0;
   int cur_len = 0;

   tstate_ring #(.N_STATES(N)) dut (
      .CLK   (CLK),
      .nCLR  (nCLR),
      .HLT   (HLT),
      .nEND  (nEND),
      .LEN   (LEN),
      .state (state),
      .tidx  (tidx),
      .last  (last),
      .ERR   (ERR)
   );

   always #5 CLK = ~CLK;

   function automatic int effl(input int len);
      return (len >= 2 && len <= N) ? len : N;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0] es;
      es = (pos == 0) ? '0 : N'(1) << (pos - 1);
      check({tag, ".state"}, 32'(state), 32'(es));
      check({tag, ".tidx"},  32'(tidx),  32'(pos));
      check({tag, ".last"},  32'(last),  32'(pos != 0 && pos == effl(cur_len)));
      check({tag, ".err"},   32'(ERR),   32'(0));
      $display("%t %s hlt=%0b nend=%0b len=%0d state=%b tidx=%0d last=%0b err=%0b",
               $time, tag, HLT, nEND, LEN, state, tidx, last, ERR);
   endtask

   // Drive inputs, let one negedge sample them, advance the model, then check.
   task automatic cycle(input string tag, input logic h, input logic ne, input int len);
      HLT = h; nEND = ne; LEN = W'(len); cur_len = len;
      @(negedge CLK);
      if (!h) begin
         if (pos == 0 || !ne || pos >= effl(len)) pos = 1;
         else pos = pos + 1;
      end
      #2;
      check_model(tag);
   endtask

   task automatic async_reset(input string tag);
      nCLR = 1'b0;
      #1;
      pos = 0;
      check_model(tag);
      #1;
      nCLR = 1'b1;
   endtask

   initial begin
      // Reset overrides active inputs
      #12;
      check_model("reset");
      nCLR = 1'b1;

      // Free run, LEN=0 falls back to the full ring
      for (int i = 0; i < 8; i++) cycle("free6", 1'b0, 1'b1, 0);

      // Short ring length 4
      for (int i = 0; i < 9; i++) cycle("len4", 1'b0, 1'b1, 4);

      // Early end in T3
      while (pos != 3) cycle("to_t3", 1'b0, 1'b1, 6);
      cycle("nend_t3", 1'b0, 1'b0, 6);
      cycle("nend_t1", 1'b0, 1'b0, 6);
      for (int i = 0; i < 7; i++) cycle("resume", 1'b0, 1'b1, 6);

      // Hold in T2 for three negedges, ignoring nEND and LEN
      while (pos != 2) cycle("to_t2", 1'b0, 1'b1, 6);
      cycle("hlt1", 1'b1, 1'b0, 2);
      cycle("hlt2", 1'b1, 1'b1, 3);
      cycle("hlt3", 1'b1, 1'b0, 0);
      cycle("hlt_off", 1'b0, 1'b1, 6);

      // LEN lowered below the current position
      while (pos != 5) cycle("to_t5", 1'b0, 1'b1, 6);
      cycle("len_drop", 1'b0, 1'b1, 3);
      for (int i = 0; i < 4; i++) cycle("len3", 1'b0, 1'b1, 3);

      // Length boundaries: 2, 1 and 7 (the latter two act as full length)
      for (int i = 0; i < 4; i++) cycle("len2", 1'b0, 1'b1, 2);
      for (int i = 0; i < 7; i++) cycle("len1", 1'b0, 1'b1, 1);
      for (int i = 0; i < 7; i++) cycle("len7", 1'b0, 1'b1, 7);

      // Asynchronous reset mid-cycle, then restart from idle
      async_reset("midreset");
      cycle("post_reset", 1'b0, 1'b0, 6);
      cycle("post_reset2", 1'b0, 1'b1, 6);

      // Illegal state injection
      force dut.state_reg = 6'b000101;
      #1;
      release dut.state_reg;
      check("forced.state", 32'(state), 32'h05);
`ifdef TSTATE_RING_SELFCHECK_EN
      HLT = 1'b1; nEND = 1'b1; LEN = W'(6); cur_len = 6;
      @(negedge CLK); #2;
      check("recover.state", 32'(state), 32'h01);
      check("recover.err", 32'(ERR), 32'(1));
      @(negedge CLK); #2;
      check("recover2.state", 32'(state), 32'h01);
      check("recover2.err", 32'(ERR), 32'(0));
      pos = 1;
`else
      HLT = 1'b0; nEND = 1'b1; LEN = W'(6); cur_len = 6;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK); #2;
         check("illegal_hold.state", 32'(state), 32'h05);
         check("illegal_hold.err", 32'(ERR), 32'(0));
      end
      async_reset("illegal_clr");
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
               int'($urandom_range(0, 7)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tstate_ring.md
TSTATE_RING -- requirements
Module: tstate_ring

Interface
REQ-001 The block SHALL have parameter N_STATES, default 6, meaning the number of T-states in the ring (legal range 2..16).
REQ-002 The block SHALL have derived localparam IDX_W, defined as $clog2(N_STATES+1), which is the width of the index and length buses.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on the negedge.
REQ-004 The block SHALL have port nCLR, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port HLT, input, 1 bit: when high, the ring holds its current state.
REQ-006 The block SHALL have port nEND, input, 1 bit: active-low early end, which forces the next state to T1.
REQ-007 The block SHALL have port LEN, input, IDX_W bits: the runtime ring length in T-states.
REQ-008 The block SHALL have port state, output, N_STATES bits: registered one-hot T-state, where bit0 is T1.
REQ-009 The block SHALL have port tidx, output, IDX_W bits: the binary T-state number (1..N_STATES), or 0 in the idle/reset state.
REQ-010 The block SHALL have port last, output, 1 bit: high while state is the final T-state of the current cycle per the effective length.
REQ-011 The block SHALL have port ERR, output, 1 bit: illegal-state flag (see Configuration).

Function
REQ-012 Effective length SHALL be LEN when 2 <= LEN <= N_STATES, and N_STATES otherwise (LEN of 0, 1, or greater than N_STATES).
REQ-013 Next-state priority on each negedge CLK SHALL be, highest first: HLT hold; illegal-state handling; idle-to-T1; nEND-low to T1; wrap; shift.
REQ-014 From idle (all zeros), with HLT low, the next state SHALL be T1 (bit0) regardless of nEND.
REQ-015 With HLT low and nEND high, state SHALL shift one bit left (Tk to Tk+1) while k < effective length.
REQ-016 At Tk with k >= effective length, the next state SHALL be T1; this covers LEN lowered mid-cycle below the current position.
REQ-017 With nEND low and HLT low in any legal state, the next state SHALL be T1; nEND low in T1 SHALL keep T1.
REQ-018 HLT high SHALL freeze state, tidx and last indefinitely; nEND and LEN SHALL be ignored while HLT is high.
REQ-019 tidx SHALL be derived combinationally from state with no extra latency; last SHALL be combinational from state and effective length.
REQ-020 State changes SHALL take effect one negedge after the inputs are sampled; inputs SHALL be sampled at the negedge.

Reset
REQ-021 nCLR low SHALL asynchronously force state to all zeros, tidx to 0, last to 0 and ERR to 0, overriding every other input.
REQ-022 Reset deasserted mid-cycle SHALL restart the sequence from idle; the first negedge after release with HLT low SHALL give T1.

Configuration
REQ-023 Macro TSTATE_RING_SELFCHECK_EN, when defined, SHALL enable detection of any non-zero, non-one-hot state.
REQ-024 With the macro defined, an illegal state SHALL cause the next negedge to load T1 and set ERR high for exactly one cycle; HLT SHALL NOT block this recovery.
REQ-025 Without the macro, ERR SHALL be tied to 0 and an illegal state SHALL be held unchanged, giving legacy behaviour.

Structure
REQ-026 A shared package tstate_pkg SHALL hold the default N_STATES, the maximum ring length of 16, and the idle constant of zero.
REQ-027 The one-hot to binary conversion for tidx SHALL be a sub-module onehot_enc, parameterised by width, outputting 0 for an all-zero input.
REQ-028 All registers SHALL live in tstate_ring; onehot_enc SHALL be purely combinational.

Verification
REQ-029 Reset then free run, N_STATES=6, LEN=0 -> the bench SHALL observe state 000000, then 000001, 000010, 000100, 001000, 010000, 100000, 000001; tidx 0,1..6,1; last high only at 100000.
REQ-030 LEN=4 -> the bench SHALL observe T1..T4 then T1; last high at 001000; bits 4 and 5 never set.
REQ-031 nEND pulsed low in T3 -> the bench SHALL observe the next state 000001; a subsequent free run SHALL resume normally.
REQ-032 HLT held high for 3 cycles in T2 -> state SHALL stay 000010 for 3 negedges, then T3 SHALL follow after HLT falls.
REQ-033 LEN changed from 6 to 3 while in T5 -> the next state SHALL be T1.
REQ-034 State forced to 000101 -> with TSTATE_RING_SELFCHECK_EN the bench SHALL observe the next state 000001 with ERR high for one cycle; without the macro the state SHALL hold 000101 and ERR SHALL stay 0.
